// File: rtl/set_pkg.sv
// Shared widths, enums and the command record for the SET core driver.
package set_pkg;
  localparam int COORD_W   = 4;
  localparam int CENTRAL_W = 24;
  localparam int RADIUS_W  = 12;
  localparam int CAND_W    = 8;

  typedef enum logic [1:0] {MODE_A, MODE_AND, MODE_XOR, MODE_ONE3} mode_e;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_VALID, S_DONE} state_e;

  typedef struct packed {
    logic [CENTRAL_W-1:0] central;
    logic [RADIUS_W-1:0]  radius;
    mode_e                mode;
  } cmd_t;
endpackage

// File: rtl/set_cmd_fifo.sv
// Small synchronous FIFO of command records; head is visible on rdata while non-empty.
module set_cmd_fifo
  import set_pkg::*;
#(
  parameter int CMD_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  cmd_t wdata,
  input  logic pop,
  output cmd_t rdata,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(CMD_DEPTH);

  cmd_t            mem [CMD_DEPTH];
  logic [AW-1:0]   wp, rp;
  logic [AW:0]     cnt;
  logic            do_push, do_pop;

  assign full    = (cnt == (AW+1)'(CMD_DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rp];

  always_ff @(posedge clk)
    if (do_push) mem[wp] <= wdata;

  // Pointers are AW bits wide, so wrap modulo CMD_DEPTH comes for free.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/set_cmd_driver.sv
// Issues queued commands to the SET core one at a time and returns each count
// (or a timeout marker) on a valid/ready result port.
module set_cmd_driver
  import set_pkg::*;
#(
  parameter int CMD_DEPTH   = 4,
  parameter int TIMEOUT_CYC = 100
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [CENTRAL_W-1:0] cmd_central,
  input  logic [RADIUS_W-1:0]  cmd_radius,
  input  logic [1:0]           cmd_mode,
  output logic                 set_en,
  output logic [CENTRAL_W-1:0] set_central,
  output logic [RADIUS_W-1:0]  set_radius,
  output logic [1:0]           set_mode,
  input  logic                 set_busy,
  input  logic                 set_valid,
  input  logic [CAND_W-1:0]    set_candidate,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [CAND_W-1:0]    res_candidate,
  output logic [1:0]           res_mode,
  output logic                 res_timeout,
  output logic                 drv_busy
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_e        state, nstate;
  logic [TW-1:0] tcnt;
  cmd_t          wcmd, head;
  logic          full, empty, pop, in_wait, expired, complete, abort;

  assign wcmd = '{central: cmd_central, radius: cmd_radius, mode: mode_e'(cmd_mode)};

  set_cmd_fifo #(.CMD_DEPTH(CMD_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid && cmd_ready),
    .wdata (wcmd),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign cmd_ready = !full;
  assign set_en    = (state == S_ISSUE);
  assign drv_busy  = (state != S_IDLE) || !empty;

  assign in_wait  = (state == S_WAIT_BUSY) || (state == S_WAIT_VALID);
  assign expired  = (tcnt == TW'(TIMEOUT_CYC - 1));
  // A stale valid is only honoured after busy has been seen, i.e. in WAIT_VALID.
  assign complete = (state == S_WAIT_VALID) && set_valid && !set_busy;
  assign abort    = in_wait && expired && !complete;

  always_comb begin
    nstate = state;
    pop    = 1'b0;
    case (state)
      S_IDLE:       if (!empty && !set_busy) begin
                      pop    = 1'b1;
                      nstate = S_ISSUE;
                    end
      S_ISSUE:      nstate = S_WAIT_BUSY;
      S_WAIT_BUSY:  if (abort) nstate = S_DONE;
                    else if (set_busy) nstate = S_WAIT_VALID;
      S_WAIT_VALID: if (complete || abort) nstate = S_DONE;
      S_DONE:       if (res_ready) nstate = S_IDLE;
      default:      nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      tcnt          <= '0;
      set_central   <= '0;
      set_radius    <= '0;
      set_mode      <= '0;
      res_valid     <= 1'b0;
      res_candidate <= '0;
      res_mode      <= '0;
      res_timeout   <= 1'b0;
    end else begin
      state <= nstate;
      if (pop) begin
        set_central <= head.central;
        set_radius  <= head.radius;
        set_mode    <= head.mode;
      end
      if (state == S_ISSUE) tcnt <= '0;
      else if (in_wait)     tcnt <= tcnt + 1'b1;
      if (complete) begin
        res_valid     <= 1'b1;
        res_candidate <= set_candidate;
        res_mode      <= set_mode;
        res_timeout   <= 1'b0;
      end else if (abort) begin
        res_valid     <= 1'b1;
        res_candidate <= '0;
        res_mode      <= set_mode;
        res_timeout   <= 1'b1;
      end else if (state == S_DONE && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/set_cmd_driver.md
Name: set_cmd_driver

Overview:
- Initiator for the SET circle-coverage counter.
- Accepts queued commands (central, radius, mode) from an upstream valid/ready port and issues each to the SET core as a one-cycle en pulse.
- Tracks the core's busy/valid handshake and returns each candidate count on a downstream valid/ready result port.
- Sits between the host/command source and the SET core. Enforces one outstanding command, never re-triggers while the core is busy, and flags a hung core with a timeout.

Parameters:
- CMD_DEPTH, 4: command FIFO entries; power of two, at least 2.
- TIMEOUT_CYC, 100: maximum cycles from the en pulse to core valid before the command is aborted. The core needs 64 scan cycles plus margin.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  upstream command present
- cmd_ready  out  1  driver can accept a command (FIFO not full)
- cmd_central  in  24  {xA,yA,xB,yB,xC,yC}, 4 bits each
- cmd_radius  in  12  {rA,rB,rC}, 4 bits each
- cmd_mode  in  2  0=A, 1=A&B, 2=A^B, 3=exactly-one-of-three
- set_en  out  1  start pulse to core
- set_central  out  24  registered central to core
- set_radius  out  12  registered radius to core
- set_mode  out  2  registered mode to core
- set_busy  in  1  core busy
- set_valid  in  1  core result valid (level; remains high until next en)
- set_candidate  in  8  core count, 0..64
- res_valid  out  1  result available
- res_ready  in  1  downstream takes result
- res_candidate  out  8  captured count
- res_mode  out  2  mode of the command that produced this result
- res_timeout  out  1  result aborted by timeout; res_candidate=0
- drv_busy  out  1  high when FSM is not in IDLE or the FIFO is non-empty

Behaviour:
- Reset (sync, rst=1 at a clk edge) sets the following:
  - set_en=0; set_central, set_radius and set_mode all 0.
  - res_valid=0, res_candidate=0, res_mode=0, res_timeout=0.
  - FIFO flushed, so cmd_ready=1 and drv_busy=0 in the next cycle.
  - FSM=IDLE, timeout counter=0.
- Reset mid-operation abandons the in-flight command with no result. The core is reset separately.
- FIFO:
  - Push on cmd_valid&&cmd_ready; cmd_ready = !full.
  - Pop only on the IDLE->ISSUE transition.
  - Push and pop in the same cycle is legal; occupancy is unchanged.
  - Pointers wrap modulo CMD_DEPTH.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_VALID, DONE.
- IDLE: if FIFO non-empty and set_busy=0, load the head into set_central/radius/mode, pop, and go to ISSUE. Otherwise stay.
- ISSUE: set_en=1 for exactly this cycle; timeout counter cleared; go to WAIT_BUSY.
- WAIT_BUSY: set_en=0; go to WAIT_VALID when set_busy=1.
  - A stale set_valid=1 from the previous command is ignored here.
- WAIT_VALID: when set_valid=1 and set_busy=0, capture set_candidate into res_candidate, res_mode=set_mode, res_timeout=0, res_valid=1; go to DONE.
- Timeout: the counter increments every cycle in WAIT_BUSY and WAIT_VALID. On reaching TIMEOUT_CYC-1 without completion: res_valid=1, res_timeout=1, res_candidate=0; go to DONE. Completion on the same cycle as expiry wins.
- DONE: hold res_* stable while res_valid=1 and res_ready=0. On res_ready=1, res_valid=0 at the next edge and the FSM goes to IDLE. A new issue can follow one cycle later.
- set_central/radius/mode stay stable from ISSUE until the next IDLE->ISSUE.
- Latency:
  - Command accepted at edge N: IDLE sees it non-empty after N, ISSUE drives set_en high in cycle N+2.
  - res_valid rises on the edge after the cycle where set_valid=1 is sampled.
- Only one command is ever outstanding at the core.

Decomposition:
- Package set_pkg holds:
  - widths COORD_W=4, CENTRAL_W=24, RADIUS_W=12, CAND_W=8;
  - mode enum MODE_A, MODE_AND, MODE_XOR, MODE_ONE3;
  - FSM state enum;
  - a command struct {central, radius, mode}.
- Sub-module set_cmd_fifo: synchronous FIFO of command structs, parameterised by CMD_DEPTH, with full/empty outputs.

Test Plan:
- Mode 0 with a real core, central A=(4,4), rA=2 -> exactly one set_en pulse; res_valid with res_candidate=13, res_timeout=0, res_mode=0.
- Mode 1 then mode 2, both with A=B=(4,4), r=2, queued back-to-back -> results in order: 13 (mode 1), then 0 (mode 2). set_en is never high while set_busy=1.
- Hold res_ready=0 with 5 commands offered -> the first is issued; cmd_ready drops after 4 more are queued; no second set_en until res_ready=1.
- Stub core never asserts busy -> after TIMEOUT_CYC cycles, res_valid=1 with res_timeout=1 and res_candidate=0; the next command then issues normally.
- Stale valid: core holds set_valid=1 from a previous run; a new command is issued -> driver waits for busy and does not capture the stale count.
- Reset in WAIT_VALID with 2 commands queued -> next cycle cmd_ready=1, drv_busy=0, res_valid=0, set_en=0.
